multicycle_control: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 105 ++++++++++
 rtl/multicycle_control_if.sv | 37 +++
 rtl/mem_wait_timer.sv | 24 ++
 rtl/multicycle_control.sv | 106 ++++++++++
 tb/tb_multicycle_control.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states,
// datapath mux encodings, fault causes and the per-state Moore control word.
package mips_ctrl_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_RTWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_FAULT
  } state_e;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Moore part of the control outputs; pc_write here covers JUMP only.
  typedef struct packed {
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;

  // Control word presented while the FSM sits in state s.
  function automatic ctrl_t state_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_rd    = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_rd = 1'b1;
        c.iord   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_wr = 1'b1;
        c.iord   = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_src        = PCSRC_ALUOUT;
        c.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit bus: opcode/handshake inputs and datapath mux/enable outputs.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_if #(parameter int unsigned CNT_W = 32);
  logic             start_i;
  logic [5:0]       Op_i;
  logic             MemReady_i;
  logic             IorD_o;
  logic             MemRd_o;
  logic             MemWr_o;
  logic             IRWrite_o;
  logic             RegDst_o;
  logic             MemtoReg_o;
  logic             RegWrite_o;
  logic             ALUSrcA_o;
  logic [1:0]       ALUSrcB_o;
  logic [1:0]       ALUOp_o;
  logic [1:0]       PCSrc_o;
  logic             PCWrite_o;
  logic             PCWriteCond_o;
  logic             Fault_o;
  logic [1:0]       FaultCause_o;
  logic [CNT_W-1:0] Retired_o;

  modport master (
    input  start_i, Op_i, MemReady_i,
    output IorD_o, MemRd_o, MemWr_o, IRWrite_o, RegDst_o, MemtoReg_o,
           RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSrc_o, PCWrite_o,
           PCWriteCond_o, Fault_o, FaultCause_o, Retired_o
  );

  modport slave (
    output start_i, Op_i, MemReady_i,
    input  IorD_o, MemRd_o, MemWr_o, IRWrite_o, RegDst_o, MemtoReg_o,
           RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSrc_o, PCWrite_o,
           PCWriteCond_o, Fault_o, FaultCause_o, Retired_o
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts not-ready cycles, cleared on state entry.
// Ports: clk_i, rst_i (async active-low), clr, en, ready, timeout_c.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  input  logic ready,
  output logic timeout_c
);
  localparam int unsigned TW = 8;

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)            cnt_q <= '0;
    else if (clr)          cnt_q <= '0;
    else if (en && !ready) cnt_q <= cnt_q + TW'(1);
  end

  assign timeout_c = (cnt_q == TW'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait timeout, sticky fault and
// retired-instruction counter.
// Ports: clk_i, rst_i (async active-low), bus (multicycle_control_if.master).
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_control_if.master bus
);
  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic             fault_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q;
  logic             wait_state, timer_clr, timeout, retire, fetch_done;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timer_clr  = (state_d != state_q);
  assign fetch_done = (state_q == S_FETCH) && bus.MemReady_i;
  assign retire     = (state_q == S_MEMWB) || (state_q == S_RTWB) || (state_q == S_ADDIWB) ||
                      (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                      ((state_q == S_MEMWR) && bus.MemReady_i);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr       (timer_clr),
    .en        (wait_state),
    .ready     (bus.MemReady_i),
    .timeout_c (timeout)
  );

  // Next-state and fault-cause selection.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE:   if (bus.start_i) state_d = S_FETCH;
      S_FETCH:  if (bus.MemReady_i) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op_i)
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FAULT;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.Op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.MemReady_i) state_d = S_MEMWB;
      S_MEMWR:  if (bus.MemReady_i) state_d = S_FETCH;
      S_EXEC:   state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RTWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
    // A ready in the last allowed cycle still wins over the timeout.
    if (wait_state && timeout && !bus.MemReady_i) begin
      state_d = S_FAULT;
      cause_d = CAUSE_TIMEOUT;
    end
  end

  // Moore outputs are registered from the next state so they track state_q.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      fault_q   <= 1'b0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
      fault_q <= (state_d == S_FAULT);
      cause_q <= cause_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.IorD_o        = ctrl_q.iord;
  assign bus.MemRd_o       = ctrl_q.mem_rd;
  assign bus.MemWr_o       = ctrl_q.mem_wr;
  assign bus.IRWrite_o     = fetch_done;
  assign bus.RegDst_o      = ctrl_q.reg_dst;
  assign bus.MemtoReg_o    = ctrl_q.mem_to_reg;
  assign bus.RegWrite_o    = ctrl_q.reg_write;
  assign bus.ALUSrcA_o     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB_o     = ctrl_q.alu_src_b;
  assign bus.ALUOp_o       = ctrl_q.alu_op;
  assign bus.PCSrc_o       = ctrl_q.pc_src;
  assign bus.PCWrite_o     = ctrl_q.pc_write | fetch_done;
  assign bus.PCWriteCond_o = ctrl_q.pc_write_cond;
  assign bus.Fault_o       = fault_q;
  assign bus.FaultCause_o  = cause_q;
  assign bus.Retired_o     = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver walks instruction phase
// sequences and pushes the expected control word per cycle; the monitor pops
// and compares on every falling edge.
module tb_multicycle_control;
  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 3;

  typedef enum {
    P_RESET, P_IDLE, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
    P_EXEC, P_RTWB, P_ADDIEX, P_ADDIWB, P_BRANCH, P_JUMP, P_FAULT
  } phase_e;

  typedef struct {
    phase_e      ph;
    logic [18:0] ctrl;
    int unsigned ret;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned ret_model = 0;
  logic [1:0]  cause_model = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b0;

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] op_of(int kind);
    case (kind)
      0: return 6'b000000;
      1: return 6'b001000;
      2: return 6'b100011;
      3: return 6'b101011;
      4: return 6'b000100;
      default: return 6'b000010;
    endcase
  endfunction

  // Expected outputs for one cycle of a given phase, straight from the state table.
  function automatic logic [18:0] exp_ctrl(phase_e p, logic rdy, logic [1:0] cause);
    logic iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcw, pcwc, flt;
    logic [1:0] srcb, aop, pcs, fc;
    {iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcw, pcwc, flt} = '0;
    {srcb, aop, pcs, fc} = '0;
    case (p)
      P_FETCH:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      P_DECODE: srcb = 2'b11;
      P_MEMADR: begin srca = 1; srcb = 2'b10; end
      P_MEMRD:  begin mrd = 1; iord = 1; end
      P_MEMWB:  begin rw = 1; m2r = 1; end
      P_MEMWR:  begin mwr = 1; iord = 1; end
      P_EXEC:   begin srca = 1; aop = 2'b10; end
      P_RTWB:   begin rw = 1; rdst = 1; end
      P_ADDIEX: begin srca = 1; srcb = 2'b10; end
      P_ADDIWB: rw = 1;
      P_BRANCH: begin srca = 1; aop = 2'b01; pcs = 2'b01; pcwc = 1; end
      P_JUMP:   begin pcs = 2'b10; pcw = 1; end
      P_FAULT:  begin flt = 1; fc = cause; end
      default: ;
    endcase
    return {iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, pcw, pcwc, flt, fc};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(phase_e ph, logic st, logic [5:0] op, logic rdy, logic rn, bit retire);
    @(posedge clk);
    #1;
    rst            = rn;
    bus.start_i    = st;
    bus.Op_i       = op;
    bus.MemReady_i = rdy;
    if (!rn) begin
      ret_model   = 0;
      cause_model = 2'b00;
    end
    sb.push_back('{ph, exp_ctrl(ph, rdy, cause_model), ret_model % (1 << CNT_W)});
    if (retire) ret_model++;
  endtask

  task automatic mem_phase(phase_e ph, logic [5:0] op, int waits, bit retire);
    repeat (waits) step(ph, rnd(), op, 1'b0, 1'b1, 1'b0);
    step(ph, rnd(), op, 1'b1, 1'b1, retire);
  endtask

  task automatic run_instr(int kind, int wf, int wm);
    logic [5:0] op;
    op = op_of(kind);
    mem_phase(P_FETCH, op, wf, 1'b0);
    step(P_DECODE, rnd(), op, rnd(), 1'b1, 1'b0);
    case (kind)
      0: begin step(P_EXEC, rnd(), op, rnd(), 1'b1, 1'b0); step(P_RTWB, rnd(), op, rnd(), 1'b1, 1'b1); end
      1: begin step(P_ADDIEX, rnd(), op, rnd(), 1'b1, 1'b0); step(P_ADDIWB, rnd(), op, rnd(), 1'b1, 1'b1); end
      2: begin
        step(P_MEMADR, rnd(), op, rnd(), 1'b1, 1'b0);
        mem_phase(P_MEMRD, op, wm, 1'b0);
        step(P_MEMWB, rnd(), op, rnd(), 1'b1, 1'b1);
      end
      3: begin
        step(P_MEMADR, rnd(), op, rnd(), 1'b1, 1'b0);
        mem_phase(P_MEMWR, op, wm, 1'b1);
      end
      4: step(P_BRANCH, rnd(), op, rnd(), 1'b1, 1'b1);
      default: step(P_JUMP, rnd(), op, rnd(), 1'b1, 1'b1);
    endcase
  endtask

  task automatic fault_cycles(int n);
    repeat (n) step(P_FAULT, rnd(), 6'($urandom_range(0, 63)), rnd(), 1'b1, 1'b0);
  endtask

  // Hold reset, release, then pulse start so the next cycle is FETCH.
  task automatic reset_start(int n);
    repeat (n) step(P_RESET, rnd(), 6'h00, rnd(), 1'b0, 1'b0);
    step(P_IDLE, 1'b0, 6'h00, rnd(), 1'b1, 1'b0);
    step(P_IDLE, 1'b0, 6'h00, rnd(), 1'b1, 1'b0);
    step(P_IDLE, 1'b1, 6'h00, rnd(), 1'b1, 1'b0);
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation.
  initial begin
    exp_t        e;
    logic [18:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.IorD_o, bus.MemRd_o, bus.MemWr_o, bus.IRWrite_o, bus.RegDst_o,
               bus.MemtoReg_o, bus.RegWrite_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUOp_o,
               bus.PCSrc_o, bus.PCWrite_o, bus.PCWriteCond_o, bus.Fault_o, bus.FaultCause_o};
        checks++;
        if (act !== e.ctrl)
          $display("FAIL ctrl[%s] t=%0t actual=%b required=%b", e.ph.name(), $time, act, e.ctrl);
        else passed++;
        checks++;
        if (bus.Retired_o !== CNT_W'(e.ret))
          $display("FAIL retired[%s] t=%0t actual=%0d required=%0d", e.ph.name(), $time, bus.Retired_o, e.ret);
        else passed++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    bus.start_i    = 1'b0;
    bus.Op_i       = 6'h00;
    bus.MemReady_i = 1'b0;

    reset_start(3);
    run_instr(0, 0, 0);   // R-type, zero wait
    run_instr(2, 0, 3);   // lw with three MEMRD wait cycles
    run_instr(4, 0, 0);   // beq
    run_instr(5, 0, 0);   // j
    run_instr(0, 3, 0);   // ready arrives exactly in the timeout cycle
    run_instr(3, 1, 3);   // sw
    run_instr(1, 2, 0);   // addi
    repeat (30) run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // Illegal opcode: fault is sticky, start is ignored, retired is kept.
    mem_phase(P_FETCH, 6'h3F, int'($urandom_range(0, 3)), 1'b0);
    step(P_DECODE, 1'b0, 6'h3F, rnd(), 1'b1, 1'b0);
    cause_model = 2'b01;
    fault_cycles(6);

    // Fetch timeout after four not-ready cycles.
    reset_start(2);
    repeat (4) step(P_FETCH, rnd(), 6'h00, 1'b0, 1'b1, 1'b0);
    cause_model = 2'b10;
    fault_cycles(3);

    // Load timeout in MEMRD.
    reset_start(1);
    run_instr(0, 0, 0);
    mem_phase(P_FETCH, 6'b100011, 0, 1'b0);
    step(P_DECODE, rnd(), 6'b100011, rnd(), 1'b1, 1'b0);
    step(P_MEMADR, rnd(), 6'b100011, rnd(), 1'b1, 1'b0);
    repeat (4) step(P_MEMRD, rnd(), 6'b100011, 1'b0, 1'b1, 1'b0);
    cause_model = 2'b10;
    fault_cycles(3);

    // Store timeout in MEMWR.
    reset_start(1);
    mem_phase(P_FETCH, 6'b101011, 1, 1'b0);
    step(P_DECODE, rnd(), 6'b101011, rnd(), 1'b1, 1'b0);
    step(P_MEMADR, rnd(), 6'b101011, rnd(), 1'b1, 1'b0);
    repeat (4) step(P_MEMWR, rnd(), 6'b101011, 1'b0, 1'b1, 1'b0);
    cause_model = 2'b10;
    fault_cycles(2);

    reset_start(1);
    repeat (10) run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) $display("FAIL drain actual=%0d pending required=0", sb.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
